// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between CPU stores and Memoria, with youngest-match load forwarding.
// Define STORE_BUF_COALESCE_EN to merge a push into a pending entry with the same word address.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    input  logic                     mem_idle,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, fwd_idx;
    logic [CW-1:0]     count_q, count_d;
    logic              full, drain, push, alloc, coal_hit;
    logic              unused_ok;

    assign unused_ok = ^ld_addr[1:0];

    always_comb begin
        full     = count_q == CW'(DEPTH);
        empty    = reset | (count_q == '0);
        count    = reset ? '0 : count_q;
        drain    = ~reset & mem_idle & (count_q != '0);
        mem_wr   = drain;
        mem_addr = (~reset & valid_q[rd_ptr_q]) ? addr_q[rd_ptr_q] : '0;
        mem_wd   = (~reset & valid_q[rd_ptr_q]) ? data_q[rd_ptr_q] : '0;
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (!reset && valid_q[fwd_idx] && addr_q[fwd_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] coal_idx;
    // The head leaving this cycle cannot absorb a merge; the push then allocates.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i][ADDR_W-1:2] == st_addr[ADDR_W-1:2] && !(drain && PW'(i) == rd_ptr_q)) begin
                coal_hit = 1'b1;
                coal_idx = PW'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    always_comb begin
        st_ready = reset | ~full | coal_hit;
        push     = ~reset & st_valid & st_ready;
        alloc    = push & ~coal_hit;
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        rd_ptr_d = drain ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = alloc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CW'(alloc) - CW'(drain);
        if (drain)
            valid_d[rd_ptr_q] = 1'b0;
        if (alloc) begin
            addr_d[wr_ptr_q]  = st_addr;
            data_d[wr_ptr_q]  = st_data;
            valid_d[wr_ptr_q] = 1'b1;
        end
`ifdef STORE_BUF_COALESCE_EN
        if (push && coal_hit)
            data_d[coal_idx] = st_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule
